// File: rtl/minimicro_pkg.sv
// Shared minimicro definitions: ISA opcode constants plus the program-loader
// state machine and error-code encodings.
package minimicro_pkg;

    localparam int unsigned OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_ADD  = 5'd1;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'd2;
    localparam logic [OPC_W-1:0] OP_AND  = 5'd3;
    localparam logic [OPC_W-1:0] OP_OR   = 5'd4;
    localparam logic [OPC_W-1:0] OP_XOR  = 5'd5;
    localparam logic [OPC_W-1:0] OP_SLL  = 5'd6;
    localparam logic [OPC_W-1:0] OP_SRL  = 5'd7;
    localparam logic [OPC_W-1:0] OP_SRA  = 5'd8;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'd9;
    localparam logic [OPC_W-1:0] OP_LUI  = 5'd10;
    localparam logic [OPC_W-1:0] OP_LW   = 5'd11;
    localparam logic [OPC_W-1:0] OP_SW   = 5'd12;
    localparam logic [OPC_W-1:0] OP_BEQ  = 5'd13;
    localparam logic [OPC_W-1:0] OP_BNE  = 5'd14;
    localparam logic [OPC_W-1:0] OP_JAL  = 5'd15;
    localparam logic [OPC_W-1:0] OP_JALR = 5'd16;
    localparam logic [OPC_W-1:0] OP_SLT  = 5'd17;
    localparam logic [OPC_W-1:0] OP_HALT = 5'd18;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } ld_state_t;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_OVERSIZE   = 2'd1,
        ERR_BAD_OPCODE = 2'd2,
        ERR_CHECKSUM   = 2'd3
    } ld_err_t;

endpackage

// File: rtl/progmem_loader.sv
// Program memory loader: parses a byte stream (count, words, XOR checksum),
// writes validated instruction words and holds the core in reset until done.
module progmem_loader
    import minimicro_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MAX_OPCODE = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code
);

    localparam logic [32:0] CAP = 33'd1 << ADDR_WIDTH;

    ld_state_t             r_state, w_next;
    logic [15:0]           r_n;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [31:0]           r_asm;
    logic [1:0]            r_bcnt;
    logic [7:0]            r_csum;
    ld_err_t               r_code;

    logic                  w_acc;
    logic [15:0]           w_hdr_n;
    logic [31:0]           w_asm_next;
    logic                  w_oversize;
    logic                  w_bad_op;
    logic                  w_last;
    logic                  w_restart;

    assign w_acc      = in_valid & in_ready;
    assign w_hdr_n    = {in_data, r_n[7:0]};
    assign w_asm_next = {in_data, r_asm[31:8]};
    assign w_oversize = {17'd0, w_hdr_n} > CAP;
    // Opcode is checked on the assembled word so a bad word never reaches WRITE.
    assign w_bad_op   = (w_asm_next[OPC_W-1:0] == '0) ||
                        (32'(w_asm_next[OPC_W-1:0]) > MAX_OPCODE);
    assign w_last     = 32'(r_idx) == (32'(r_n) - 32'd1);
    assign w_restart  = start && (r_state == ST_IDLE || r_state == ST_DONE ||
                                  r_state == ST_ERROR);

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: if (start) w_next = ST_HDR0;
            ST_HDR0: if (w_acc) w_next = ST_HDR1;
            ST_HDR1: begin
                if (w_acc) begin
                    if (w_oversize)          w_next = ST_ERROR;
                    else if (w_hdr_n == '0)  w_next = ST_CSUM;
                    else                     w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_acc && r_bcnt == 2'd3) w_next = w_bad_op ? ST_ERROR : ST_WRITE;
            end
            ST_WRITE: w_next = w_last ? ST_CSUM : ST_DATA;
            ST_CSUM: if (w_acc) w_next = (in_data == r_csum) ? ST_DONE : ST_ERROR;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        mem_we   = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        cpu_rst  = 1'b1;
        unique case (r_state)
            ST_HDR0, ST_HDR1, ST_DATA, ST_CSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_WRITE: begin
                busy   = 1'b1;
                mem_we = 1'b1;
            end
            ST_DONE: begin
                done    = 1'b1;
                cpu_rst = 1'b0;
            end
            ST_ERROR: err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n    <= '0;
            r_idx  <= '0;
            r_asm  <= '0;
            r_bcnt <= '0;
            r_csum <= '0;
            r_code <= ERR_NONE;
        end else if (w_restart) begin
            r_idx  <= '0;
            r_asm  <= '0;
            r_bcnt <= '0;
            r_csum <= '0;
            r_code <= ERR_NONE;
        end else begin
            unique case (r_state)
                ST_HDR0: if (w_acc) r_n[7:0] <= in_data;
                ST_HDR1: begin
                    if (w_acc) begin
                        r_n[15:8] <= in_data;
                        if (w_oversize) r_code <= ERR_OVERSIZE;
                    end
                end
                ST_DATA: begin
                    if (w_acc) begin
                        r_asm  <= w_asm_next;
                        r_csum <= r_csum ^ in_data;
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3 && w_bad_op) r_code <= ERR_BAD_OPCODE;
                    end
                end
                ST_WRITE: if (!w_last) r_idx <= r_idx + ADDR_WIDTH'(1);
                ST_CSUM: begin
                    if (w_acc && in_data != r_csum) r_code <= ERR_CHECKSUM;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = r_idx;
    assign mem_wdata = r_asm;
    assign err_code  = r_code;

endmodule

// File: tb/tb_progmem_loader.sv
// Directed self-checking bench for progmem_loader: streams hand-built byte
// sequences and checks memory writes and status outputs.
module tb_progmem_loader;

    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_rst;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;

    int checks = 0;
    int errors = 0;

    logic [7:0]    stream[$];
    int unsigned   wr_cnt = 0;
    logic [AW-1:0] wr_addr[0:511];
    logic [31:0]   wr_data[0:511];

    progmem_loader #(.ADDR_WIDTH(AW), .MAX_OPCODE(18)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst(cpu_rst),
        .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Write-strobe monitor: records every memory write seen on the port.
    always @(negedge clk) begin
        if (mem_we === 1'b1 && wr_cnt < 512) begin
            wr_addr[wr_cnt] = mem_addr;
            wr_data[wr_cnt] = mem_wdata;
            wr_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit jitter);
        bit sent = 0;
        if (jitter) repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        for (int n = 0; n < 20 && !sent; n++) begin
            if (in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                sent = 1;
            end else begin
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        if (!sent) begin
            checks++; errors++;
            $display("FAIL send_byte timeout: byte %h not accepted, in_ready=%b required 1", b, in_ready);
        end
    endtask

    task automatic send_stream(input bit jitter);
        foreach (stream[i]) send_byte(stream[i], jitter);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
        checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr got %h exp 00", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_status busy/done/err got %b exp 000", {busy, done, err}); end
        checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code got %0d exp 0", err_code); end
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst got %b exp 1", cpu_rst); end
        rst = 1'b0;
    endtask

    task automatic test_basic_load();
        int unsigned base = wr_cnt;
        pulse_start();
        checks++; if ({busy, in_ready, cpu_rst} !== 3'b111) begin errors++; $display("FAIL basic_hdr0 busy/in_ready/cpu_rst got %b exp 111", {busy, in_ready, cpu_rst}); end
        stream = '{8'h02, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h07};
        send_stream(0);
        checks++; if (wr_cnt - base !== 2) begin errors++; $display("FAIL basic_write_count got %0d exp 2", wr_cnt - base); end
        checks++; if (wr_addr[base] !== 8'h00 || wr_data[base] !== 32'h00000006) begin errors++; $display("FAIL basic_word0 got %h:%h exp 00:00000006", wr_addr[base], wr_data[base]); end
        checks++; if (wr_addr[base+1] !== 8'h01 || wr_data[base+1] !== 32'h00000001) begin errors++; $display("FAIL basic_word1 got %h:%h exp 01:00000001", wr_addr[base+1], wr_data[base+1]); end
        checks++; if ({done, err, cpu_rst, busy} !== 4'b1000) begin errors++; $display("FAIL basic_done done/err/cpu_rst/busy got %b exp 1000", {done, err, cpu_rst, busy}); end
        checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL basic_err_code got %0d exp 0", err_code); end
    endtask

    task automatic test_empty_load();
        int unsigned base = wr_cnt;
        pulse_start();
        checks++; if ({done, cpu_rst} !== 2'b01) begin errors++; $display("FAIL empty_restart done/cpu_rst got %b exp 01", {done, cpu_rst}); end
        stream = '{8'h00, 8'h00, 8'h00};
        send_stream(0);
        checks++; if (wr_cnt - base !== 0) begin errors++; $display("FAIL empty_writes got %0d exp 0", wr_cnt - base); end
        checks++; if ({done, err, cpu_rst} !== 3'b100) begin errors++; $display("FAIL empty_done done/err/cpu_rst got %b exp 100", {done, err, cpu_rst}); end
    endtask

    task automatic test_bad_opcode();
        int unsigned base = wr_cnt;
        pulse_start();
        stream = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        send_stream(0);
        @(negedge clk);
        checks++; if (wr_cnt - base !== 0) begin errors++; $display("FAIL badop19_writes got %0d exp 0", wr_cnt - base); end
        checks++; if ({err, done, cpu_rst, in_ready} !== 4'b1010) begin errors++; $display("FAIL badop19_status err/done/cpu_rst/in_ready got %b exp 1010", {err, done, cpu_rst, in_ready}); end
        checks++; if (err_code !== 2'd2) begin errors++; $display("FAIL badop19_err_code got %0d exp 2", err_code); end
        // Opcode field zero with upper bits set is still illegal.
        base = wr_cnt;
        pulse_start();
        checks++; if ({err, err_code} !== 3'b000) begin errors++; $display("FAIL badop_restart err/err_code got %b exp 000", {err, err_code}); end
        stream = '{8'h01, 8'h00, 8'hE0, 8'h00, 8'h00, 8'h00};
        send_stream(0);
        @(negedge clk);
        checks++; if (wr_cnt - base !== 0 || err_code !== 2'd2) begin errors++; $display("FAIL badop0 writes=%0d err_code=%0d exp 0 and 2", wr_cnt - base, err_code); end
    endtask

    task automatic test_checksum_error();
        int unsigned base = wr_cnt;
        pulse_start();
        stream = '{8'h01, 8'h00, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00};
        send_stream(0);
        checks++; if (wr_cnt - base !== 1 || wr_data[base] !== 32'h00000012 || wr_addr[base] !== 8'h00) begin errors++; $display("FAIL csum_write count=%0d data=%h exp 1 write 00000012 at 00", wr_cnt - base, wr_data[base]); end
        checks++; if ({err, cpu_rst, err_code} !== 4'b1111) begin errors++; $display("FAIL csum_err err/cpu_rst/err_code got %b exp 1111", {err, cpu_rst, err_code}); end
    endtask

    task automatic test_oversize();
        int unsigned base = wr_cnt;
        pulse_start();
        stream = '{8'h01, 8'h01};
        send_stream(0);
        checks++; if ({err, in_ready, busy} !== 3'b100 || err_code !== 2'd1) begin errors++; $display("FAIL oversize err/in_ready/busy=%b err_code=%0d exp 100 and 1", {err, in_ready, busy}, err_code); end
        checks++; if (wr_cnt - base !== 0) begin errors++; $display("FAIL oversize_writes got %0d exp 0", wr_cnt - base); end
    endtask

    task automatic test_full_capacity();
        int unsigned base = wr_cnt;
        int mism = 0;
        logic [7:0] cs = 8'h00;
        logic [7:0] op;
        logic [7:0] ib;
        pulse_start();
        stream = '{8'h00, 8'h01};
        for (int i = 0; i < 256; i++) begin
            op = 8'((i % 18) + 1);
            ib = 8'(i);
            stream.push_back(op); stream.push_back(ib);
            stream.push_back(8'hA5); stream.push_back(8'h00);
            cs = cs ^ op ^ ib ^ 8'hA5;
        end
        stream.push_back(cs);
        send_stream(0);
        checks++; if (wr_cnt - base !== 256) begin errors++; $display("FAIL full_write_count got %0d exp 256", wr_cnt - base); end
        for (int i = 0; i < 256; i++) begin
            if (wr_addr[base+i] !== 8'(i) || wr_data[base+i] !== {8'h00, 8'hA5, 8'(i), 8'((i % 18) + 1)}) mism++;
        end
        checks++; if (mism !== 0) begin errors++; $display("FAIL full_words got %0d mismatching words exp 0", mism); end
        checks++; if (wr_addr[base+255] !== 8'hFF || wr_data[base+255] !== 32'h00A5FF04) begin errors++; $display("FAIL full_last got %h:%h exp ff:00a5ff04", wr_addr[base+255], wr_data[base+255]); end
        checks++; if ({done, err, cpu_rst} !== 3'b100) begin errors++; $display("FAIL full_done done/err/cpu_rst got %b exp 100", {done, err, cpu_rst}); end
    endtask

    task automatic test_busy_start_and_stall();
        int unsigned base = wr_cnt;
        pulse_start();
        send_byte(8'h01, 0);
        pulse_start();
        repeat (5) @(negedge clk);
        checks++; if ({busy, in_ready, done, err} !== 4'b1100) begin errors++; $display("FAIL stall_status busy/in_ready/done/err got %b exp 1100", {busy, in_ready, done, err}); end
        stream = '{8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h05};
        send_stream(0);
        checks++; if (wr_cnt - base !== 1 || wr_data[base] !== 32'h00000005) begin errors++; $display("FAIL busy_start_write count=%0d data=%h exp 1 write 00000005", wr_cnt - base, wr_data[base]); end
        checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL busy_start_done done/err got %b exp 10", {done, err}); end
    endtask

    task automatic test_reset_midload();
        int unsigned base = wr_cnt;
        bit reached = 0;
        pulse_start();
        stream = '{8'h03, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        send_stream(1);
        for (int n = 0; n < 10 && !reached; n++) begin
            if (wr_cnt - base == 2) reached = 1;
            else begin @(posedge clk); #1; end
        end
        checks++; if (!reached) begin errors++; $display("FAIL midload_writes got %0d exp 2 before reset", wr_cnt - base); end
        @(negedge clk);
        rst = 1'b1; in_data = 8'h5A; in_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        checks++; if ({in_ready, mem_we, busy, done, err, cpu_rst} !== 6'b000001) begin errors++; $display("FAIL midload_rst_status in_ready/we/busy/done/err/cpu_rst got %b exp 000001", {in_ready, mem_we, busy, done, err, cpu_rst}); end
        checks++; if (mem_addr !== 8'h00 || mem_wdata !== 32'h0 || err_code !== 2'd0) begin errors++; $display("FAIL midload_rst_regs addr=%h wdata=%h err_code=%0d exp 00 0 0", mem_addr, mem_wdata, err_code); end
        base = wr_cnt;
        pulse_start();
        stream = '{8'h03, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
        send_stream(1);
        checks++; if (wr_cnt - base !== 3 || wr_addr[base+2] !== 8'h02 || wr_data[base+2] !== 32'h00000003) begin errors++; $display("FAIL reload_writes count=%0d last=%h:%h exp 3 and 02:00000003", wr_cnt - base, wr_addr[base+2], wr_data[base+2]); end
        checks++; if ({done, err, cpu_rst} !== 3'b100) begin errors++; $display("FAIL reload_done done/err/cpu_rst got %b exp 100", {done, err, cpu_rst}); end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_empty_load();
        test_bad_opcode();
        test_checksum_error();
        test_oversize();
        test_full_capacity();
        test_busy_start_and_stall();
        test_reset_midload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
